// File: rtl/mul_op_sequencer.sv
// mul_op_sequencer: control stage in front of a sequential shift-add
// multiplier. It accepts an operand pair and drives load low for one cycle
// (init), then high for WAIT_CYCLES cycles (run). It then captures the
// product and offers it on a valid/ready output handshake.
module mul_op_sequencer #(
    parameter int SIZE        = 8,
    parameter int WAIT_CYCLES = 2*SIZE+2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   in_a,
    input  logic [SIZE-1:0]   in_b,
    output logic              mul_load,
    output logic [SIZE-1:0]   mul_a,
    output logic [SIZE-1:0]   mul_b,
    input  logic [2*SIZE-1:0] mul_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] out_product,
    output logic              busy,
    output logic [7:0]        op_count
);

    // A zero wait would sample the product before the multiplier has run.
    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("mul_op_sequencer: WAIT_CYCLES must be >= 1");
    end

    localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [SIZE-1:0]     mul_a_q, mul_a_d;
    logic [SIZE-1:0]     mul_b_q, mul_b_d;
    logic [2*SIZE-1:0]   out_product_q, out_product_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          op_count_q, op_count_d;

    // Decoded strictly from the state register, so these never glitch on inputs.
    assign mul_load    = (state_q == RUN);
    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign op_count    = op_count_q;

    // Next-state and datapath updates for the IDLE -> INIT -> RUN -> DONE sequence.
    always_comb begin
        // NOTE: every target gets a hold default first so no path infers a latch.
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        out_product_d = out_product_q;
        out_valid_d   = out_valid_q;
        op_count_d    = op_count_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mul_a_d = in_a;
                    mul_b_d = in_b;
                    state_d = INIT;
                end
            end
            INIT: begin
                wcnt_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                wcnt_d = wcnt_q + 1'b1;
                if (wcnt_q == WCNT_LAST) begin
                    out_product_d = mul_result;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                // Operands stay on the bus until the product is taken.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= IDLE;
            wcnt_q        <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            out_product_q <= '0;
            out_valid_q   <= 1'b0;
            op_count_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            out_product_q <= out_product_d;
            out_valid_q   <= out_valid_d;
            op_count_q    <= op_count_d;
        end
    end

endmodule

// File: tb/tb_mul_op_sequencer.sv
// tb_mul_op_sequencer: directed bench for mul_op_sequencer with a small
// behavioural shift-add multiplier whose product only becomes valid after
// enough load-high cycles.
module tb_mul_op_sequencer;

    localparam int SIZE = 8;
    localparam int WAIT = 2*SIZE+2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [SIZE-1:0]   in_a, in_b;
    logic              mul_load;
    logic [SIZE-1:0]   mul_a, mul_b;
    logic [2*SIZE-1:0] mul_result;
    logic              out_valid;
    logic              out_ready;
    logic [2*SIZE-1:0] out_product;
    logic              busy;
    logic [7:0]        op_count;

    int       n_checks = 0;
    int       n_errors = 0;
    logic [7:0] exp_ops = 8'd0;

    mul_op_sequencer #(.SIZE(SIZE), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Multiplier model: load low clears it; the product is valid only once
    // load has been high for 16 edges, garbage before that.
    int mcnt;
    always_ff @(posedge clk) begin
        if (!mul_load) begin
            mcnt       <= 0;
            mul_result <= 16'h0000;
        end else begin
            mcnt       <= mcnt + 1;
            mul_result <= (mcnt >= 15) ? 16'(mul_a * mul_b) : 16'hDEAD;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid after the accept edge; returns edges counted and
    // whether operands stayed stable on the bus.
    task automatic wait_out(input logic [7:0] a, input logic [7:0] b,
                            output int n, output logic stable);
        n = 0;
        stable = 1'b1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
            if (mul_a !== a || mul_b !== b) stable = 1'b0;
            if (n == 1) check("run_load_high", mul_load, 1);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_ops++;
        check("hs_valid_low", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
        check("hs_op_count", op_count, exp_ops);
    endtask

    // One full operation with `hold` cycles of backpressure in DONE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
        int n;
        logic stable, steady;
        logic [15:0] exp_p;
        exp_p = 16'(a) * 16'(b);
        in_valid = 1'b1; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0;
        check("init_load_low", mul_load, 0);
        check("init_busy", busy, 1);
        check("init_in_ready", in_ready, 0);
        wait_out(a, b, n, stable);
        check("latency", n, WAIT+1);
        check("operands_stable", stable, 1);
        check("product", out_product, exp_p);
        check("done_load_low", mul_load, 0);
        check("done_in_ready", in_ready, 0);
        steady = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_product !== exp_p || in_ready !== 1'b0 ||
                mul_load !== 1'b0 || mul_a !== a || mul_b !== b) steady = 1'b0;
        end
        if (hold > 0) check("backpressure_steady", steady, 1);
        handshake();
    endtask

    initial begin
        int n;
        logic stable;
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_load", mul_load, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_op_count", op_count, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_product", out_product, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // 1 and 2: basic operation and maximum operands.
        run_op(8'd3, 8'd5, 0);
        run_op(8'd255, 8'd255, 0);

        // 3: backpressure for 10 cycles; out_ready pulsed in IDLE is ignored.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_ready_ignored", op_count, exp_ops);
        run_op(8'd12, 8'd34, 10);

        // 4: a second pair held during an operation waits for IDLE.
        in_valid = 1'b1; in_a = 8'd10; in_b = 8'd10;
        tick();
        in_a = 8'd7; in_b = 8'd9;
        wait_out(8'd10, 8'd10, n, stable);
        check("q_latency", n, WAIT+1);
        check("q_not_taken", stable, 1);
        check("q_product1", out_product, 16'd100);
        handshake();
        check("q_after_hs_mul_a", mul_a, 10);
        tick();
        in_valid = 1'b0;
        check("q_accept_mul_a", mul_a, 7);
        check("q_accept_mul_b", mul_b, 9);
        wait_out(8'd7, 8'd9, n, stable);
        check("q_product2", out_product, 16'd63);
        handshake();

        // 5: reset in RUN with wcnt=5 abandons the operation.
        in_valid = 1'b1; in_a = 8'd6; in_b = 8'd6;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        check("pre_rst_load", mul_load, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_load", mul_load, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_op_count", op_count, 0);
        exp_ops = 8'd0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < WAIT + 4; i++) begin
            tick();
            if (out_valid !== 1'b0) check("no_stale_valid", out_valid, 0);
        end
        run_op(8'd2, 8'd4, 0);

        // 6: 256 back-to-back operations wrap op_count.
        reset = 1'b1;
        #1;
        exp_ops = 8'd0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 256; i++) begin
            run_op(8'(i), 8'(255 - i), 0);
            if (i == 254) check("count_255", op_count, 255);
        end
        check("count_wrap", op_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
